// File: rtl/apb_master_pkg.sv
// Shared types for the APB master bridge: FSM state encoding and APB data width.
package apb_master_pkg;

  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } apb_state_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response handshake plus APB3 bus of the bridge. The master modport is the bridge's
// own view. The slave modport is the view of whoever drives commands and models the peripherals.
interface apb_master_bridge_if
  import apb_master_pkg::*;
#(
  parameter int ADDR_W = 16
) ();

  logic                  CMD_VALID;
  logic                  CMD_READY;
  logic                  CMD_WRITE;
  logic [ADDR_W-1:0]     CMD_ADDR;
  logic [APB_DATA_W-1:0] CMD_WDATA;

  logic                  RSP_VALID;
  logic                  RSP_READY;
  logic [APB_DATA_W-1:0] RSP_RDATA;
  logic                  RSP_ERR;
  logic                  RSP_TIMEOUT;

  logic                  M_APB_PSEL;
  logic                  M_APB_PENABLE;
  logic                  M_APB_PWRITE;
  logic [ADDR_W-1:0]     M_APB_PADDR;
  logic [APB_DATA_W-1:0] M_APB_PWDATA;
  logic                  M_APB_PREADY;
  logic [APB_DATA_W-1:0] M_APB_PRDATA;
  logic                  M_APB_PSLVERR;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY,
    input  M_APB_PREADY, M_APB_PRDATA, M_APB_PSLVERR,
    output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
    output M_APB_PSEL, M_APB_PENABLE, M_APB_PWRITE, M_APB_PADDR, M_APB_PWDATA
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY,
    output M_APB_PREADY, M_APB_PRDATA, M_APB_PSLVERR,
    input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
    input  M_APB_PSEL, M_APB_PENABLE, M_APB_PWRITE, M_APB_PADDR, M_APB_PWDATA
  );

endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 initiator. It turns one accepted command into a SETUP/ACCESS transfer
// and returns the slave's answer, or a timeout abort, as a response held until consumed.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 256
) (
  input  logic CLK,
  input  logic RST_N,
  output logic BUSY,
  apb_master_bridge_if.master bus
);

  localparam bit TIMEOUT_EN = (TIMEOUT > 0);
  localparam int CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_EN ? TIMEOUT - 1 : 0);

  apb_state_t state;
  apb_state_t state_next;

  logic                  cmd_ready;
  logic                  cmd_accept;
  logic                  access_done;
  logic                  access_timeout;
  logic [CNT_W-1:0]      wait_cnt;

  logic                  pwrite_q;
  logic [ADDR_W-1:0]     paddr_q;
  logic [APB_DATA_W-1:0] pwdata_q;

  logic                  rsp_valid_q;
  logic [APB_DATA_W-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;

  // A pending response blocks new commands, so there is never more than one transfer in flight.
  assign cmd_ready  = RST_N & (state == ST_IDLE) & ~rsp_valid_q;
  assign cmd_accept = bus.CMD_VALID & cmd_ready;

  assign access_done    = (state == ST_ACCESS) & bus.M_APB_PREADY;
  assign access_timeout = TIMEOUT_EN & (state == ST_ACCESS) & ~bus.M_APB_PREADY
                          & (wait_cnt == CNT_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (cmd_accept) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: if (access_done || access_timeout) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Read commands force PWDATA to zero so that stale write data never appears on the bus.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else if (cmd_accept) begin
      pwrite_q <= bus.CMD_WRITE;
      paddr_q  <= bus.CMD_ADDR;
      pwdata_q <= bus.CMD_WRITE ? bus.CMD_WDATA : '0;
    end
  end

  // Counts ACCESS edges with PREADY low. It is cleared on the SETUP edge that enters ACCESS.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt <= '0;
    end else if (state == ST_SETUP) begin
      wait_cnt <= '0;
    end else if (state == ST_ACCESS && !bus.M_APB_PREADY) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else if (access_done) begin
      rsp_valid_q   <= 1'b1;
      rsp_rdata_q   <= pwrite_q ? '0 : bus.M_APB_PRDATA;
      rsp_err_q     <= bus.M_APB_PSLVERR;
      rsp_timeout_q <= 1'b0;
    end else if (access_timeout) begin
      rsp_valid_q   <= 1'b1;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b1;
      rsp_timeout_q <= 1'b1;
    end else if (rsp_valid_q && bus.RSP_READY) begin
      rsp_valid_q   <= 1'b0;
    end
  end

  assign bus.CMD_READY     = cmd_ready;
  assign bus.RSP_VALID     = rsp_valid_q;
  assign bus.RSP_RDATA     = rsp_rdata_q;
  assign bus.RSP_ERR       = rsp_err_q;
  assign bus.RSP_TIMEOUT   = rsp_timeout_q;

  assign bus.M_APB_PSEL    = (state != ST_IDLE);
  assign bus.M_APB_PENABLE = (state == ST_ACCESS);
  assign bus.M_APB_PWRITE  = pwrite_q;
  assign bus.M_APB_PADDR   = paddr_q;
  assign bus.M_APB_PWDATA  = pwdata_q;

  assign BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: a slave model plays out per-transfer wait states and
// a reference model predicts each response. A monitor then pops and checks the predictions.
module tb_apb_master_bridge;

  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 4;

  typedef struct {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    int                waits;
    logic [31:0]       rdata;
    logic              err;
  } xfer_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
    int          latency;
  } rsp_t;

  logic clk  = 1'b0;
  logic rstN = 1'b1;
  logic busy;

  apb_master_bridge_if #(.ADDR_W(ADDR_W)) bus ();

  apb_master_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK   (clk),
    .RST_N (rstN),
    .BUSY  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int rspReadyMode = 0;
  int lastHsEdge = -1;
  int lastAcceptEdge = -1;
  xfer_t slaveQ[$];
  rsp_t  expQ[$];
  int    acceptQ[$];

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // A normal response appears 2 edges after accept (SETUP edge, then first ACCESS edge), plus one
  // per wait state. A timeout ends on the TIMEOUT-th ACCESS edge.
  function automatic rsp_t modelResponse(input xfer_t x);
    rsp_t r;
    if (x.waits >= TIMEOUT) begin
      r.rdata = 32'h0; r.err = 1'b1; r.timeout = 1'b1; r.latency = 1 + TIMEOUT;
    end else begin
      r.rdata = x.write ? 32'h0 : x.rdata; r.err = x.err; r.timeout = 1'b0; r.latency = 2 + x.waits;
    end
    return r;
  endfunction

  function automatic int expectedAccessCycles(input xfer_t x);
    return (x.waits >= TIMEOUT) ? TIMEOUT : x.waits + 1;
  endfunction

  function automatic xfer_t mkXfer(input logic w, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                                   input int waits, input logic [31:0] rd, input logic e);
    xfer_t x;
    x.write = w; x.addr = a; x.wdata = wd; x.waits = waits; x.rdata = rd; x.err = e;
    return x;
  endfunction

  task automatic applyStimulus(input xfer_t x, input bit expectRsp);
    int n = 0;
    slaveQ.push_back(x);
    if (expectRsp) expQ.push_back(modelResponse(x));
    @(negedge clk);
    bus.CMD_VALID = 1'b1;
    bus.CMD_WRITE = x.write;
    bus.CMD_ADDR  = x.addr;
    bus.CMD_WDATA = x.wdata;
    while (!bus.CMD_READY && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) checkOutput("cmdAcceptBound", 32'(n), 32'd0);
    @(negedge clk);
    bus.CMD_VALID = 1'b0;
    bus.CMD_WRITE = 1'($urandom);
    bus.CMD_ADDR  = ADDR_W'($urandom);
    bus.CMD_WDATA = $urandom;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((expQ.size() != 0 || bus.RSP_VALID || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) checkOutput("drainBound", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    bus.RSP_READY = 1'b0;
    forever begin
      @(negedge clk);
      case (rspReadyMode)
        0:       bus.RSP_READY = ($urandom_range(0, 3) != 0);
        1:       bus.RSP_READY = 1'b0;
        default: bus.RSP_READY = 1'b1;
      endcase
    end
  end

  // Slave model: checks the address phase and the hold of the bus, then answers on the scheduled ACCESS cycle.
  initial begin
    xfer_t cur;
    int accessCycles = 0;
    int setupCycles = 0;
    bit active = 1'b0;
    cur = mkXfer(1'b0, '0, 32'h0, 0, 32'h0, 1'b0);
    bus.M_APB_PREADY  = 1'b0;
    bus.M_APB_PRDATA  = 32'h0;
    bus.M_APB_PSLVERR = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        active = 1'b0;
        bus.M_APB_PREADY = 1'b0;
      end else if (bus.M_APB_PSEL) begin
        if (!active) begin
          if (slaveQ.size() == 0) checkOutput("unexpectedSetup", 32'd1, 32'd0);
          else cur = slaveQ.pop_front();
          active = 1'b1; setupCycles = 0; accessCycles = 0;
        end
        checkOutput("busyInTransfer", 32'(busy), 32'd1);
        checkOutput("paddr", 32'(bus.M_APB_PADDR), 32'(cur.addr));
        checkOutput("pwrite", 32'(bus.M_APB_PWRITE), 32'(cur.write));
        checkOutput("pwdata", bus.M_APB_PWDATA, cur.write ? cur.wdata : 32'h0);
        if (!bus.M_APB_PENABLE) begin
          setupCycles++;
          bus.M_APB_PREADY  = 1'($urandom_range(0, 1));
          bus.M_APB_PRDATA  = $urandom;
          bus.M_APB_PSLVERR = 1'($urandom);
        end else begin
          if (accessCycles == 0) checkOutput("singleSetupCycle", 32'(setupCycles), 32'd1);
          if (accessCycles == cur.waits) begin
            bus.M_APB_PREADY  = 1'b1;
            bus.M_APB_PRDATA  = cur.rdata;
            bus.M_APB_PSLVERR = cur.err;
          end else begin
            bus.M_APB_PREADY  = 1'b0;
            bus.M_APB_PRDATA  = $urandom;
            bus.M_APB_PSLVERR = 1'($urandom);
          end
          accessCycles++;
        end
      end else begin
        if (active) begin
          checkOutput("accessCycleCount", 32'(accessCycles), 32'(expectedAccessCycles(cur)));
          active = 1'b0;
        end
        bus.M_APB_PREADY  = 1'($urandom_range(0, 1));
        bus.M_APB_PRDATA  = $urandom;
        bus.M_APB_PSLVERR = 1'($urandom);
      end
    end
  end

  // Monitor: samples just after the falling edge, when inputs already hold their next-edge values.
  initial begin
    rsp_t exp;
    bit seen = 1'b0;
    int acc;
    exp.rdata = 32'h0; exp.err = 1'b0; exp.timeout = 1'b0; exp.latency = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rstN) begin
        seen = 1'b0;
        acceptQ.delete();
      end else begin
        if (bus.CMD_VALID && bus.CMD_READY) begin
          acceptQ.push_back(cycleCount + 1);
          lastAcceptEdge = cycleCount + 1;
        end
        if (bus.RSP_VALID) begin
          checkOutput("cmdReadyLowWhileRsp", 32'(bus.CMD_READY), 32'd0);
          if (!seen) begin
            seen = 1'b1;
            if (expQ.size() == 0) begin
              checkOutput("unexpectedRsp", 32'd1, 32'd0);
            end else begin
              exp = expQ.pop_front();
              checkOutput("busyAfterDone", 32'(busy), 32'd0);
              if (acceptQ.size() == 0) begin
                checkOutput("rspWithoutAccept", 32'd1, 32'd0);
              end else begin
                acc = acceptQ.pop_front();
                checkOutput("acceptToRspEdges", 32'(cycleCount - acc), 32'(exp.latency));
              end
            end
          end
          checkOutput("rspRdata", bus.RSP_RDATA, exp.rdata);
          checkOutput("rspErr", 32'(bus.RSP_ERR), 32'(exp.err));
          checkOutput("rspTimeout", 32'(bus.RSP_TIMEOUT), 32'(exp.timeout));
          if (bus.RSP_READY) begin
            seen = 1'b0;
            lastHsEdge = cycleCount + 1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    xfer_t x;
    int n;
    bus.CMD_VALID = 1'b0;
    bus.CMD_WRITE = 1'b0;
    bus.CMD_ADDR  = '0;
    bus.CMD_WDATA = 32'h0;

    #1 rstN = 1'b0;
    #1;
    checkOutput("rstPsel", 32'(bus.M_APB_PSEL), 32'd0);
    checkOutput("rstPenable", 32'(bus.M_APB_PENABLE), 32'd0);
    checkOutput("rstPwrite", 32'(bus.M_APB_PWRITE), 32'd0);
    checkOutput("rstPaddr", 32'(bus.M_APB_PADDR), 32'd0);
    checkOutput("rstPwdata", bus.M_APB_PWDATA, 32'h0);
    checkOutput("rstRspValid", 32'(bus.RSP_VALID), 32'd0);
    checkOutput("rstRspRdata", bus.RSP_RDATA, 32'h0);
    checkOutput("rstRspErr", 32'(bus.RSP_ERR), 32'd0);
    checkOutput("rstRspTimeout", 32'(bus.RSP_TIMEOUT), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstCmdReady", 32'(bus.CMD_READY), 32'd0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    #1 checkOutput("cmdReadyAfterRst", 32'(bus.CMD_READY), 32'd1);

    $display("[TB] zero-wait write, wait-state read, slave error");
    applyStimulus(mkXfer(1'b1, 16'h0004, 32'hDEADBEEF, 0, 32'hA5A5A5A5, 1'b0), 1'b1);
    waitIdle();
    applyStimulus(mkXfer(1'b0, 16'h000C, 32'h12345678, 2, 32'h00000055, 1'b0), 1'b1);
    waitIdle();
    applyStimulus(mkXfer(1'b0, 16'h0010, 32'h0, 1, 32'hCAFEF00D, 1'b1), 1'b1);
    waitIdle();

    $display("[TB] timeout abort, then ready on the last allowed cycle");
    applyStimulus(mkXfer(1'b0, 16'h0020, 32'h0, 50, 32'h11111111, 1'b0), 1'b1);
    waitIdle();
    applyStimulus(mkXfer(1'b0, 16'h0024, 32'h0, TIMEOUT - 1, 32'h22222222, 1'b0), 1'b1);
    waitIdle();

    $display("[TB] response backpressure");
    rspReadyMode = 1;
    applyStimulus(mkXfer(1'b1, 16'h0030, 32'h0BADCAFE, 0, 32'h0, 1'b0), 1'b1);
    n = 0;
    while (!bus.RSP_VALID && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bpRspValid", 32'(bus.RSP_VALID), 32'd1);
    fork
      applyStimulus(mkXfer(1'b0, 16'h0034, 32'h0, 0, 32'h33333333, 1'b0), 1'b1);
      begin
        repeat (5) @(negedge clk);
        rspReadyMode = 2;
      end
    join
    checkOutput("acceptAfterHandshake", 32'(lastAcceptEdge), 32'(lastHsEdge + 1));
    waitIdle();
    rspReadyMode = 0;

    $display("[TB] asynchronous reset during ACCESS");
    applyStimulus(mkXfer(1'b1, 16'h0040, 32'h44444444, 10, 32'h0, 1'b0), 1'b0);
    n = 0;
    while (!bus.M_APB_PENABLE && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reachedAccess", 32'(bus.M_APB_PENABLE), 32'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("rstMidPsel", 32'(bus.M_APB_PSEL), 32'd0);
    checkOutput("rstMidPenable", 32'(bus.M_APB_PENABLE), 32'd0);
    checkOutput("rstMidBusy", 32'(busy), 32'd0);
    checkOutput("rstMidPaddr", 32'(bus.M_APB_PADDR), 32'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("postRstCmdReady", 32'(bus.CMD_READY), 32'd1);
    checkOutput("postRstRspValid", 32'(bus.RSP_VALID), 32'd0);
    applyStimulus(mkXfer(1'b0, 16'h0044, 32'h0, 1, 32'h5A5A0001, 1'b0), 1'b1);
    waitIdle();

    $display("[TB] randomized transfers");
    for (int i = 0; i < 40; i++) begin
      x.write = 1'($urandom_range(0, 1));
      x.addr  = ADDR_W'($urandom);
      x.wdata = $urandom;
      x.waits = $urandom_range(0, TIMEOUT + 1);
      x.rdata = $urandom;
      x.err   = ($urandom_range(0, 4) == 0);
      applyStimulus(x, 1'b1);
    end
    waitIdle();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB3 initiator. Converts a valid/ready command/response interface from a local bus master (CPU data port, DMA) into APB transfers toward the peripheral slaves (interrupt controller, timers, UART).
- Owns the SETUP/ACCESS sequencing, holds PADDR/PWDATA stable, captures PRDATA/PSLVERR, and aborts a transfer if the slave never raises PREADY.

Parameters:
- ADDR_W, 16, width of CMD_ADDR and M_APB_PADDR.
- TIMEOUT, 256, max consecutive ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  command accepted when CMD_VALID & CMD_READY at a rising edge.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  ADDR_W  byte address.
- CMD_WDATA  in  32  write data.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  response consumed when RSP_VALID & RSP_READY at a rising edge.
- RSP_RDATA  out  32  read data; 0 for writes and timeouts.
- RSP_ERR  out  1  PSLVERR seen or timeout.
- RSP_TIMEOUT  out  1  response produced by timeout abort.
- BUSY  out  1  state != IDLE.
- M_APB_PSEL  out  1  APB select.
- M_APB_PENABLE  out  1  APB enable.
- M_APB_PWRITE  out  1  APB direction.
- M_APB_PADDR  out  ADDR_W  APB address.
- M_APB_PWDATA  out  32  APB write data.
- M_APB_PREADY  in  1  slave ready.
- M_APB_PRDATA  in  32  slave read data.
- M_APB_PSLVERR  in  1  slave error.

Behaviour:
- Reset (RST_N low, asynchronous, takes effect immediately):
  - State = IDLE.
  - All outputs 0, except CMD_READY, which is 1 once RST_N is released.
  - Timeout counter = 0, response register cleared.
  - Reset during SETUP/ACCESS drops PSEL/PENABLE at once and discards the transfer; no response is produced.
- States:
  - IDLE -> SETUP on command accept.
  - SETUP -> ACCESS unconditionally, 1 cycle.
  - ACCESS -> IDLE on PREADY or timeout.
- Output encoding by state: IDLE PSEL=0 PENABLE=0; SETUP PSEL=1 PENABLE=0; ACCESS PSEL=1 PENABLE=1.
- All APB outputs come from flops, never combinational from CMD_*.
- Command capture:
  - CMD_READY = (state==IDLE) & ~RSP_VALID.
  - On accept, CMD_WRITE/ADDR/WDATA are registered into PWRITE/PADDR/PWDATA.
  - These hold unchanged through SETUP and ACCESS and keep their last value in IDLE.
  - When PWRITE=0, PWDATA is driven 0.
- Latency: accept at edge T -> SETUP during T+1 -> ACCESS from T+2.
- Completion: a rising edge in ACCESS with PREADY=1 sets the response register and the next cycle is IDLE with PSEL=0.
  - RSP_VALID = 1.
  - RSP_RDATA = PRDATA for reads, 0 for writes.
  - RSP_ERR = PSLVERR.
  - RSP_TIMEOUT = 0.
  - Minimum command-accept to RSP_VALID: 3 cycles (zero-wait slave).
- Response hold: RSP_* stay stable until the RSP_VALID & RSP_READY edge, then RSP_VALID=0 (data fields need not clear). No new command is accepted while RSP_VALID=1.
- Timeout (TIMEOUT>0):
  - Counter clears on entry to ACCESS and increments on each ACCESS edge with PREADY=0.
  - When PREADY=0 on the TIMEOUT-th such edge: go to IDLE, RSP_VALID=1, RSP_ERR=1, RSP_TIMEOUT=1, RSP_RDATA=0.
  - PREADY=1 on that same edge wins: normal completion.
  - Counter width = $clog2(TIMEOUT+1), saturating logic not required.
  - TIMEOUT=0: wait forever.
- PRDATA/PSLVERR are sampled only on the completing edge; values during wait states are ignored.
- Address passes through unmodified; alignment is the slave's concern.

Decomposition:
- Package apb_master_pkg holds:
  - typedef enum logic [1:0] apb_state_t {ST_IDLE, ST_SETUP, ST_ACCESS};
  - localparam APB_DATA_W = 32.
- No sub-module: the timeout counter is a few lines inline; a single flat module, target ~150-200 lines.

Test Plan:
- Zero-wait write: cmd write addr 0x0004 data 0xDEADBEEF, slave PREADY=1 in ACCESS -> exactly one SETUP cycle and one ACCESS cycle with PADDR/PWDATA stable; RSP_VALID 3 cycles after accept; RSP_ERR=0, RSP_RDATA=0.
- Wait-state read: cmd read addr 0x000C, slave holds PREADY=0 for 2 ACCESS cycles and then returns PRDATA=0x00000055 -> PSEL/PENABLE high 3 ACCESS cycles; RSP_RDATA=0x55; garbage PRDATA during wait cycles ignored.
- Slave error: read with PSLVERR=1 at PREADY -> RSP_ERR=1, RSP_TIMEOUT=0.
- Timeout with TIMEOUT=4 and PREADY stuck 0 -> abort after 4 ACCESS cycles; PSEL drops; RSP_ERR=1, RSP_TIMEOUT=1, RSP_RDATA=0.
  - Repeat with PREADY=1 on the 4th cycle -> normal completion.
- Backpressure: hold RSP_READY=0 for 5 cycles with CMD_VALID=1 -> CMD_READY stays 0 and RSP_* stay stable; the second command is accepted on the cycle after the response handshake.
- Async reset asserted in ACCESS -> PSEL/PENABLE go 0 before the next clock edge; after release, CMD_READY=1, RSP_VALID=0, and a new transfer completes normally.
